// File: rtl/fft_job_scheduler_if.sv
// Handshake bundle between the FFT job scheduler (master) and the frame FIFOs / FFT core / demux (slave).
interface fft_job_scheduler_if #(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned SEL_W   = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant_start;
  logic               fft_start;
  logic               fft_out_valid;
  logic               fft_edone;
  logic [SEL_W-1:0]   mux_sel;
  logic [SEL_W-1:0]   dmux_sel;
  logic               busy;
  logic [NUM_REQ-1:0] done_pulse;
  logic               frame_err;
  logic               wdt_err;
  logic               fft_abort;

  modport master (
    input  req, fft_out_valid, fft_edone,
    output grant_start, fft_start, mux_sel, dmux_sel, busy,
           done_pulse, frame_err, wdt_err, fft_abort
  );

  modport slave (
    output req, fft_out_valid, fft_edone,
    input  grant_start, fft_start, mux_sel, dmux_sel, busy,
           done_pulse, frame_err, wdt_err, fft_abort
  );
endinterface

// File: rtl/fft_job_scheduler.sv
// Round-robin scheduler sharing one FFT engine among NUM_REQ frame sources.
// Define FFT_WDT_EN to add a RUN-state watchdog that aborts a stalled FFT job.
module fft_job_scheduler #(
  parameter int unsigned NUM_REQ    = 6,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned FRAME_LEN  = 128,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input logic                clk,
  input logic                rst,
  fft_job_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   mux_q, mux_d;
  logic [SEL_W-1:0]   dmux_q, dmux_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               ferr_q, ferr_d;
  logic [SEL_W-1:0]   winner, idx;
  logic               found;

`ifdef FFT_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             wdt_err_q, wdt_err_d;
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (WDT_CYCLES == 0);
`endif

  // First requesting source above last_grant, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = SEL_W'((32'(last_q) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign cnt_inc = (bus.fft_out_valid && (cnt_q != CNT_W'(FRAME_LEN))) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    mux_d   = mux_q;
    dmux_d  = dmux_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    start_d = 1'b0;
    done_d  = '0;
    ferr_d  = 1'b0;
`ifdef FFT_WDT_EN
    wdt_d     = wdt_q;
    wdt_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Start pulses are registered on this edge so they land in the LOAD cycle
        if (found) begin
          sel_d   = winner;
          mux_d   = winner;
          last_d  = winner;
          grant_d = NUM_REQ'(1) << winner;
          start_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dmux_d  = sel_q;
        cnt_d   = '0;
        state_d = RUN;
`ifdef FFT_WDT_EN
        wdt_d   = '0;
`endif
      end
      RUN: begin
        cnt_d = cnt_inc;
`ifdef FFT_WDT_EN
        wdt_d = wdt_q + WDT_W'(1);
`endif
        if (bus.fft_edone) begin
          if (cnt_inc == CNT_W'(FRAME_LEN)) done_d = NUM_REQ'(1) << sel_q;
          else                              ferr_d = 1'b1;
          state_d = IDLE;
        end
`ifdef FFT_WDT_EN
        else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
          wdt_err_d = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      mux_q   <= '0;
      dmux_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      done_q  <= '0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FFT_WDT_EN
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      mux_q   <= mux_d;
      dmux_q  <= dmux_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      start_q <= start_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef FFT_WDT_EN
      wdt_q     <= wdt_d;
      wdt_err_q <= wdt_err_d;
`endif
    end
  end

  assign bus.grant_start = grant_q;
  assign bus.fft_start   = start_q;
  assign bus.mux_sel     = mux_q;
  assign bus.dmux_sel    = dmux_q;
  assign bus.busy        = busy_q;
  assign bus.done_pulse  = done_q;
  assign bus.frame_err   = ferr_q;
`ifdef FFT_WDT_EN
  assign bus.wdt_err     = wdt_err_q;
  assign bus.fft_abort   = wdt_err_q;
`else
  assign bus.wdt_err     = 1'b0;
  assign bus.fft_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_fft_job_scheduler.sv
// Directed bench for fft_job_scheduler: expected grant order kept in a scoreboard queue.
module tb_fft_job_scheduler;
  localparam int unsigned NUM_REQ    = 6;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned FRAME_LEN  = 128;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned WDT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   cur_src = 0;

  fft_job_scheduler_if #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) bus();

  fft_job_scheduler #(
    .NUM_REQ(NUM_REQ), .SEL_W(SEL_W), .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " grant_start"}, 32'(bus.grant_start), 0);
    chk({tag, " fft_start"},   32'(bus.fft_start),   0);
    chk({tag, " mux_sel"},     32'(bus.mux_sel),     0);
    chk({tag, " dmux_sel"},    32'(bus.dmux_sel),    0);
    chk({tag, " busy"},        32'(bus.busy),        0);
    chk({tag, " done_pulse"},  32'(bus.done_pulse),  0);
    chk({tag, " frame_err"},   32'(bus.frame_err),   0);
    chk({tag, " wdt_err"},     32'(bus.wdt_err),     0);
    chk({tag, " fft_abort"},   32'(bus.fft_abort),   0);
  endtask

  // Called in the LOAD cycle: pop the scoreboard and check the start pulses
  task automatic expect_grant(input string tag);
    int src;
    chk({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    src = exp_q.pop_front();
    chk({tag, " grant_start"}, 32'(bus.grant_start), 32'(1) << src);
    chk({tag, " fft_start"},   32'(bus.fft_start),   1);
    chk({tag, " mux_sel"},     32'(bus.mux_sel),     32'(src));
    chk({tag, " busy"},        32'(bus.busy),        1);
    cur_src = src;
  endtask

  // From the LOAD cycle: deliver nval samples, then fft_edone (optionally with the last sample)
  task automatic finish_job(input string tag, input int nval, input bit overlap, input bit exp_done);
    tick();
    chk({tag, " grant_drop"}, 32'(bus.grant_start), 0);
    chk({tag, " start_drop"}, 32'(bus.fft_start),   0);
    chk({tag, " dmux_sel"},   32'(bus.dmux_sel),    32'(cur_src));
    for (int i = 0; i < nval; i++) begin
      bus.fft_out_valid = 1'b1;
      if (overlap && i == nval - 1) bus.fft_edone = 1'b1;
      tick();
    end
    bus.fft_out_valid = 1'b0;
    if (!overlap) begin
      bus.fft_edone = 1'b1;
      tick();
    end
    bus.fft_edone = 1'b0;
    chk({tag, " done_pulse"}, 32'(bus.done_pulse), exp_done ? (32'(1) << cur_src) : 32'(0));
    chk({tag, " frame_err"},  32'(bus.frame_err),  exp_done ? 32'(0) : 32'(1));
    chk({tag, " busy_fall"},  32'(bus.busy),        0);
    chk({tag, " idle_gap"},   32'(bus.grant_start), 0);
    tick();
    chk({tag, " done_1cyc"},  32'(bus.done_pulse), 0);
    chk({tag, " ferr_1cyc"},  32'(bus.frame_err),  0);
  endtask

  initial begin
    int seen;
    bit bad;
    rst = 1'b1;
    bus.req = '0;
    bus.fft_out_valid = 1'b0;
    bus.fft_edone = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("idle_no_req busy", 32'(bus.busy), 0);

    // Single source 0, full frame
    bus.req = 6'b000001;
    exp_q.push_back(0);
    tick();
    expect_grant("src0");
    chk("src0 dmux_pre", 32'(bus.dmux_sel), 0);
    bus.req = '0;
    finish_job("src0", 128, 1'b0, 1'b1);

    // All sources held: round-robin 0..5,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.req = 6'b111111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
    exp_q.push_back(0);
    tick();
    for (int k = 0; k < 7; k++) begin
      expect_grant("rr");
      if (k == 6) bus.req = '0;
      finish_job("rr", 128, 1'b0, 1'b1);
    end

    // Short frame then over-long frame on source 2
    bus.req = 6'b000100;
    exp_q.push_back(2);
    tick();
    expect_grant("short");
    bus.req = '0;
    finish_job("short", 127, 1'b0, 1'b0);
    bus.req = 6'b000100;
    exp_q.push_back(2);
    tick();
    expect_grant("long");
    bus.req = '0;
    finish_job("long", 130, 1'b0, 1'b1);

    // fft_edone while idle is ignored; selects hold
    bus.fft_edone = 1'b1;
    tick();
    bus.fft_edone = 1'b0;
    chk("idle_edone frame_err", 32'(bus.frame_err),   0);
    chk("idle_edone done",      32'(bus.done_pulse),  0);
    chk("idle_edone grant",     32'(bus.grant_start), 0);
    chk("idle_edone busy",      32'(bus.busy),        0);
    chk("idle_edone mux_hold",  32'(bus.mux_sel),     2);
    chk("idle_edone dmux_hold", 32'(bus.dmux_sel),    2);

    // req arrives together with a stray fft_edone; last sample coincides with fft_edone
    bus.req = 6'b010000;
    bus.fft_edone = 1'b1;
    exp_q.push_back(4);
    tick();
    bus.fft_edone = 1'b0;
    expect_grant("src4");
    chk("src4 frame_err", 32'(bus.frame_err), 0);
    bus.req = '0;
    finish_job("src4", 128, 1'b1, 1'b1);

    // Reset in the middle of RUN
    bus.req = 6'b000001;
    exp_q.push_back(0);
    tick();
    expect_grant("midrst");
    bus.req = '0;
    tick();
    bus.fft_out_valid = 1'b1;
    repeat (40) tick();
    bus.fft_out_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    bus.req = 6'b100000;
    exp_q.push_back(5);
    tick();
    expect_grant("src5");
    bus.req = '0;
    finish_job("src5", 128, 1'b0, 1'b1);

    // Stalled job: no fft_edone
    bus.req = 6'b000010;
    exp_q.push_back(1);
    tick();
    expect_grant("stall");
    bus.req = '0;
    tick();
`ifdef FFT_WDT_EN
    seen = 0;
    for (int k = 1; k <= int'(WDT_CYCLES) + 8; k++) begin
      tick();
      if (bus.wdt_err) begin
        seen = k;
        break;
      end
    end
    chk("wdt cycle", 32'(seen), 32'(WDT_CYCLES));
    chk("wdt abort", 32'(bus.fft_abort), 1);
    chk("wdt busy",  32'(bus.busy), 0);
    chk("wdt done",  32'(bus.done_pulse), 0);
    tick();
    chk("wdt 1cyc",  32'(bus.wdt_err), 0);
`else
    bad = 1'b0;
    seen = 0;
    repeat (3 * WDT_CYCLES) begin
      tick();
      if (!bus.busy) bad = 1'b1;
      if (bus.wdt_err || bus.fft_abort) seen++;
    end
    chk("stall busy_held", 32'(bad),  0);
    chk("stall no_wdt",    32'(seen), 0);
    bus.fft_edone = 1'b1;
    tick();
    bus.fft_edone = 1'b0;
    chk("stall frame_err", 32'(bus.frame_err), 1);
    chk("stall busy_fall", 32'(bus.busy), 0);
`endif

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
